trivium_stream_xor: RTL and testbench

- Downstream consumer of the trivium keystream core.
- Drives the core's advance enable and discards the warm-up bits.
- Packs the serial keystream into bytes and XORs each byte with an incoming data byte over valid/ready handshakes, producing cipher/plain bytes.
- Sits between the trivium instance and the top-level byte I/O.

---
 rtl/trivium_stream_xor_if.sv | 20 ++
 rtl/trivium_stream_xor.sv | 109 ++++++++++
 tb/tb_trivium_stream_xor.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/trivium_stream_xor_if.sv
// Byte-stream handshake bundle for trivium_stream_xor: din in, dout out,
// each with its own valid/ready pair.
interface trivium_stream_xor_if;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;

  modport master (
    output din, din_valid, dout_ready,
    input  din_ready, dout, dout_valid
  );

  modport slave (
    input  din, din_valid, dout_ready,
    output din_ready, dout, dout_valid
  );
endinterface

// File: rtl/trivium_stream_xor.sv
// Trivium keystream consumer: discards warm-up bits, packs keystream into bytes
// and XORs them onto a byte stream. Define TRIV_MSB_FIRST_EN for MSB-first packing.
module trivium_stream_xor #(
  parameter int unsigned WARMUP_CYCLES = 1152,
  parameter int unsigned WCNT_W        = 11
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ks_bit,
  output logic                   ks_en,
  output logic                   warm_done,
  trivium_stream_xor_if.slave    io
);

  typedef enum logic [1:0] {WARM, FILL, FULL} state_e;

  localparam logic [WCNT_W-1:0] WARM_MAX = WCNT_W'(WARMUP_CYCLES);

  state_e            state_q, state_d;
  logic [WCNT_W-1:0] warm_cnt_q, warm_cnt_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        key_q, key_d;
  logic              kfull_q, kfull_d;
  logic [7:0]        dout_q, dout_d;
  logic              dout_valid_q, dout_valid_d;
  logic              warm_done_q, warm_done_d;
  logic [2:0]        bit_pos;
  logic              xfer;

  // Gated by rst_n so the core, which shares the reset, never sees an advance while held.
  assign ks_en        = rst_n & (state_q != FULL);
  assign warm_done    = warm_done_q;
  assign io.din_ready = kfull_q & (~dout_valid_q | io.dout_ready);
  assign io.dout      = dout_q;
  assign io.dout_valid = dout_valid_q;
  assign xfer         = io.din_valid & io.din_ready;

  always_comb begin
    state_d      = state_q;
    warm_cnt_d   = warm_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    key_d        = key_q;
    kfull_d      = kfull_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    warm_done_d  = warm_done_q;
`ifdef TRIV_MSB_FIRST_EN
    bit_pos      = 3'd7 - bit_cnt_q;
`else
    bit_pos      = bit_cnt_q;
`endif

    unique case (state_q)
      WARM: begin
        // Saturating count; with zero warm-up this leaves on the first edge.
        if (warm_cnt_q != WARM_MAX) warm_cnt_d = warm_cnt_q + 1'b1;
        if (warm_cnt_d == WARM_MAX) begin
          warm_done_d = 1'b1;
          state_d     = FILL;
        end
      end
      FILL: begin
        key_d[bit_pos] = ks_bit;
        bit_cnt_d      = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          kfull_d = 1'b1;
          state_d = FULL;
        end
      end
      FULL: begin
        if (xfer) begin
          kfull_d = 1'b0;
          state_d = FILL;
        end
      end
      default: state_d = WARM;
    endcase

    if (xfer) begin
      dout_d       = io.din ^ key_q;
      dout_valid_d = 1'b1;
    end else if (io.dout_ready) begin
      dout_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= WARM;
      warm_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      key_q        <= '0;
      kfull_q      <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      warm_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      warm_cnt_q   <= warm_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      key_q        <= key_d;
      kfull_q      <= kfull_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      warm_done_q  <= warm_done_d;
    end
  end

endmodule

// File: tb/tb_trivium_stream_xor.sv
// Bench for trivium_stream_xor: a fixed vector table plus random traffic checked
// against a keystream-position scoreboard (byte j uses bits W+8j..W+8j+7).
module tb_trivium_stream_xor;
  localparam int unsigned W     = 4;
  localparam int unsigned NBITS = 4096;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  trivium_stream_xor_if ifw();
  trivium_stream_xor_if ifd();

  logic ks_bit, ks_en, warm_done;
  logic def_ks_en, def_warm_done;
  logic def_ks_bit = 1'b0;

  trivium_stream_xor #(.WARMUP_CYCLES(W), .WCNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .ks_bit(ks_bit), .ks_en(ks_en),
    .warm_done(warm_done), .io(ifw)
  );

  trivium_stream_xor dut_def (
    .clk(clk), .rst_n(rst_n), .ks_bit(def_ks_bit), .ks_en(def_ks_en),
    .warm_done(def_warm_done), .io(ifd)
  );

  // Keystream source: the core advances one position per edge with ks_en=1.
  bit          ks_stream [0:NBITS-1];
  int unsigned ks_idx;
  assign ks_bit = ks_stream[ks_idx];
  always @(posedge clk or negedge rst_n)
    if (!rst_n) ks_idx <= 0;
    else if (ks_en) ks_idx <= ks_idx + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] key_of(input int unsigned j);
    logic [7:0] k;
    for (int i = 0; i < 8; i++) begin
`ifdef TRIV_MSB_FIRST_EN
      k[7-i] = ks_stream[W + 8*j + i];
`else
      k[i] = ks_stream[W + 8*j + i];
`endif
    end
    return k;
  endfunction

  logic [7:0]  exp_q[$];
  int unsigned xfers;
  int unsigned cyc;
  logic        prev_hold;
  logic [7:0]  prev_dout;

  task automatic cycle(input logic v, input logic [7:0] d, input logic rdy,
                       output logic pushed, output logic popped, output logic [7:0] popval);
    @(negedge clk);
    ifw.din_valid  = v;
    ifw.din        = d;
    ifw.dout_ready = rdy;
    #1;
    cyc++;
    if (prev_hold) begin
      check("hold_valid", ifw.dout_valid, 1);
      check("hold_dout", ifw.dout, prev_dout);
    end
    popped = ifw.dout_valid && ifw.dout_ready;
    popval = ifw.dout;
    if (popped) begin
      if (exp_q.size() == 0) check("sb_spurious_pop", exp_q.size(), 1);
      else check("sb_dout", ifw.dout, exp_q.pop_front());
    end
    pushed = ifw.din_valid && ifw.din_ready;
    if (pushed) begin
      exp_q.push_back(d ^ key_of(xfers));
      xfers++;
    end
    prev_hold = ifw.dout_valid && !ifw.dout_ready;
    prev_dout = ifw.dout;
  endtask

  task automatic push_wait(input logic [7:0] d, input logic rdy, input int unsigned budget);
    logic pu, po;
    logic [7:0] pv;
    pu = 1'b0;
    for (int unsigned n = 0; n < budget && !pu; n++) cycle(1'b1, d, rdy, pu, po, pv);
    if (!pu) check("push_timeout", pu, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n          = 1'b0;
    ifw.din_valid  = 1'($urandom);
    ifw.din        = 8'($urandom);
    ifw.dout_ready = 1'($urandom);
    #1;
    check("rst_dout", ifw.dout, 0);
    check("rst_dout_valid", ifw.dout_valid, 0);
    check("rst_din_ready", ifw.din_ready, 0);
    check("rst_ks_en", ks_en, 0);
    check("rst_warm_done", warm_done, 0);
    check("rst_def_ks_en", def_ks_en, 0);
    check("rst_def_warm_done", def_warm_done, 0);
    exp_q.delete();
    xfers     = 0;
    cyc       = 0;
    prev_hold = 1'b0;
    for (int i = 0; i < int'(NBITS); i++) ks_stream[i] = 1'($urandom);
    @(negedge clk);
    ifw.din_valid  = 1'b0;
    ifw.dout_ready = 1'b0;
    rst_n          = 1'b1;
    #1;
    check("rel_ks_en", ks_en, 1);
  endtask

  task automatic measure_warm(output int unsigned e4, output int unsigned ed);
    e4 = 0;
    ed = 0;
    for (int unsigned e = 1; e <= 1300 && (e4 == 0 || ed == 0); e++) begin
      @(posedge clk);
      #1;
      if (e4 == 0 && warm_done) e4 = e;
      if (ed == 0 && def_warm_done) ed = e;
    end
  endtask

  typedef struct {
    logic [7:0] bits;   // bits[i] is the i-th keystream bit after warm-up
    logic [7:0] din;
    logic [7:0] exp_lsb;
    logic [7:0] exp_msb;
  } vec_t;

  vec_t tbl [6];

  initial begin
    logic pu, po;
    logic [7:0] pv, last_din, exp_v;
    int unsigned e4, ed, last_cyc, npush, bp_push;
    logic last_pop_nopush;

    ifd.din = '0; ifd.din_valid = 1'b0; ifd.dout_ready = 1'b0;
    ifw.din = '0; ifw.din_valid = 1'b0; ifw.dout_ready = 1'b0;

    tbl[0] = '{8'h4D, 8'hFF, 8'hB2, 8'h4D};
    tbl[1] = '{8'hFF, 8'h00, 8'hFF, 8'hFF};
    tbl[2] = '{8'h01, 8'h00, 8'h01, 8'h80};
    tbl[3] = '{8'h00, 8'h5A, 8'h5A, 8'h5A};
    tbl[4] = '{8'hF0, 8'h0F, 8'hFF, 8'h00};
    tbl[5] = '{8'h3C, 8'hA5, 8'h99, 8'h99};

    // Reset values and warm-up length for both parameterisations.
    do_reset();
    check("rel_def_ks_en", def_ks_en, 1);
    measure_warm(e4, ed);
    check("warm_edges_w4", e4, W);
    check("warm_edges_default", ed, 1152);
    check("def_ks_en_fill", def_ks_en, 1);

    // Table vectors, din_valid held from release; 9-cycle byte period.
    do_reset();
    for (int k = 0; k < 6; k++)
      for (int i = 0; i < 8; i++) ks_stream[W + 8*k + i] = tbl[k].bits[i];
    last_cyc = 0;
    for (int k = 0; k < 6; k++) begin
      push_wait(tbl[k].din, 1'b1, 30);
      if (k == 0) check("first_ready_cycle", cyc, W + 8);
      else check("tbl_gap", cyc - last_cyc, 9);
      last_cyc = cyc;
      cycle(1'b0, 8'h00, 1'b1, pu, po, pv);
      check("tbl_latency", po, 1);
`ifdef TRIV_MSB_FIRST_EN
      exp_v = tbl[k].exp_msb;
`else
      exp_v = tbl[k].exp_lsb;
`endif
      check("tbl_dout", pv, exp_v);
    end

    // Backpressure: held output, refill, core stalls, then pop+push together.
    push_wait(8'($urandom), 1'b0, 30);
    bp_push = 0;
    for (int n = 0; n < 12; n++) begin
      cycle(1'b1, 8'($urandom), 1'b0, pu, po, pv);
      if (pu) bp_push++;
    end
    check("bp_no_push", bp_push, 0);
    check("bp_ks_en", ks_en, 0);
    check("bp_din_ready", ifw.din_ready, 0);
    check("bp_valid", ifw.dout_valid, 1);
    cycle(1'b1, 8'($urandom), 1'b1, pu, po, pv);
    check("bp_push", pu, 1);
    check("bp_pop", po, 1);
    cycle(1'b0, 8'h00, 1'b0, pu, po, pv);
    check("bp_valid_kept", ifw.dout_valid, 1);
    cycle(1'b0, 8'h00, 1'b1, pu, po, pv);

    // Back-to-back with an all-ones keystream from the next byte on.
    pu = 1'b0;
    for (int n = 0; n < 20 && !ifw.din_ready; n++) cycle(1'b0, 8'h00, 1'b1, pu, po, pv);
    for (int unsigned i = ks_idx; i < NBITS; i++) ks_stream[i] = 1'b1;
    npush = 0;
    last_pop_nopush = 1'b0;
    for (int n = 0; n < 60; n++) begin
      cycle(1'b1, 8'($urandom), 1'b1, pu, po, pv);
      if (last_pop_nopush) check("b2b_valid_drop", po, 0);
      if (po && npush >= 2) check("b2b_dout", pv, last_din ^ 8'hFF);
      last_pop_nopush = po && !pu;
      if (pu) begin
        if (npush >= 1) check("b2b_gap", cyc - last_cyc, 9);
        last_cyc = cyc;
        last_din = ifw.din;
        npush++;
      end
    end

    // Random traffic against the scoreboard.
    for (int unsigned i = ks_idx; i < NBITS; i++) ks_stream[i] = 1'($urandom);
    for (int n = 0; n < 300; n++)
      cycle(1'($urandom_range(0, 9) < 7), 8'($urandom), 1'($urandom_range(0, 9) < 6), pu, po, pv);
    for (int n = 0; n < 20 && exp_q.size() != 0; n++) cycle(1'b0, 8'h00, 1'b1, pu, po, pv);
    check("drain_empty", exp_q.size(), 0);

    // Reset mid-fill with a pending output; warm-up must rerun and use fresh bits.
    do_reset();
    measure_warm(e4, ed);
    push_wait(key_of(0) ^ 8'hA5, 1'b0, 30);
    for (int n = 0; n < 3; n++) cycle(1'b0, 8'h00, 1'b0, pu, po, pv);
    check("mid_pending_dout", ifw.dout, 8'hA5);
    do_reset();
    measure_warm(e4, ed);
    check("rewarm_edges_w4", e4, W);
    check("rewarm_edges_default", ed, 1152);
    push_wait(8'h00, 1'b1, 30);
    cycle(1'b0, 8'h00, 1'b1, pu, po, pv);
    check("fresh_pop", po, 1);
    check("fresh_dout", pv, key_of(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
